// File: rtl/core_run_ctrl.sv
// core_run_ctrl: reset-sequence, run and verdict controller for the single-cycle core
//   clk, rst(async, active-high) | start level, begins a run from IDLE or DONE
//   pc, mem_we, mem_addr, mem_wdata: observed core activity
//   core_rst_n, running, done, pass, reason, exit_code, cycle_count: control and verdict
module core_run_ctrl #(
    parameter int XLEN                    = 32,
    parameter int CNT_W                   = 32,
    parameter int RESET_CYCLES            = 2,
    parameter int MAX_CYCLES              = 1000,
    parameter int STALL_LIMIT             = 4,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_00FC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [XLEN-1:0]  pc,
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    output logic             core_rst_n,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic [2:0]       reason,
    output logic [XLEN-1:0]  exit_code,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [RW-1:0] rst_cnt;
    logic [SW-1:0] stall_cnt;
    logic [XLEN-1:0] last_pc;
    logic tohost_hit, pc_match, stall_hit, timeout_hit, end_hit, rst_last;
    assign core_rst_n = state == RUN;
    assign running = state == RUN;
    assign done = state == DONE;
    always_comb begin
        tohost_hit = mem_we && mem_addr == TOHOST_ADDR;
        // last_pc is stale on the first RUN cycle, so that cycle never matches
        pc_match = cycle_count != CNT_W'(1) && pc == last_pc;
        // this match is the one that takes the counter to STALL_LIMIT-1
        stall_hit = pc_match && stall_cnt == SW'(STALL_LIMIT - 2);
        // the visible count reads MAX_CYCLES on the last permitted RUN cycle
        timeout_hit = cycle_count == CNT_W'(MAX_CYCLES);
        end_hit = tohost_hit || stall_hit || timeout_hit;
        rst_last = rst_cnt == RW'(RESET_CYCLES - 1);
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RESET : IDLE;
            RESET:   state_nx = rst_last ? RUN : RESET;
            RUN:     state_nx = end_hit ? DONE : RUN;
            default: state_nx = start ? RESET : DONE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt <= '0;
            stall_cnt <= '0;
            last_pc <= '0;
            cycle_count <= '0;
            pass <= 1'b0;
            reason <= 3'd0;
            exit_code <= '0;
        end else begin
            case (state)
                RESET: begin
                    rst_cnt <= rst_cnt + RW'(1);
                    if (rst_last)
                        cycle_count <= CNT_W'(1);
                end
                RUN: begin
                    last_pc <= pc;
                    stall_cnt <= pc_match ? stall_cnt + SW'(1) : '0;
                    if (end_hit) begin
                        reason <= tohost_hit ? (mem_wdata == XLEN'(1) ? 3'd1 : 3'd2) : stall_hit ? 3'd4 : 3'd3;
                        pass <= tohost_hit && mem_wdata == XLEN'(1);
                        exit_code <= tohost_hit && mem_wdata != XLEN'(1) ? mem_wdata >> 1 : '0;
                    end else
                        cycle_count <= cycle_count + CNT_W'(1);
                end
                default: begin
                    if (start) begin
                        rst_cnt <= '0;
                        stall_cnt <= '0;
                        cycle_count <= '0;
                        pass <= 1'b0;
                        reason <= 3'd0;
                        exit_code <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: scoreboard bench for core_run_ctrl (RESET_CYCLES=2, MAX_CYCLES=20, STALL_LIMIT=4)
module tb_core_run_ctrl;
    logic clk = 0, rst, start, mem_we, core_rst_n, running, done, pass;
    logic [31:0] pc, mem_addr, mem_wdata, exit_code, cycle_count;
    logic [2:0] reason;
    int checks = 0, passes = 0;
    typedef struct {
        logic [2:0] reason;
        logic pass;
        logic [31:0] exit_code;
        logic [31:0] cnt;
    } exp_t;
    exp_t q[$];
    exp_t e;
    core_run_ctrl #(.XLEN(32), .CNT_W(32), .RESET_CYCLES(2), .MAX_CYCLES(20), .STALL_LIMIT(4),
                    .TOHOST_ADDR(32'h0000_00FC)) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_rst_n(core_rst_n), .running(running), .done(done), .pass(pass),
        .reason(reason), .exit_code(exit_code), .cycle_count(cycle_count));
    always #5 clk = ~clk;

    task automatic cyc(input logic [31:0] p, input logic we, input logic [31:0] a, input logic [31:0] d);
        pc = p;
        mem_we = we;
        mem_addr = a;
        mem_wdata = d;
        @(negedge clk);
    endtask

    task automatic go_run(output int lows);
        start = 1;
        @(negedge clk);
        start = 0;
        lows = 0;
        for (int i = 0; i < 10 && core_rst_n !== 1'b1; i++) begin
            lows++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int lows;
        rst = 1;
        @(negedge clk);
        checks++; if ({core_rst_n, running, done, pass} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {core_rst_n, running, done, pass}); else passes++;
        checks++; if (reason !== 3'd0 || exit_code !== 0 || cycle_count !== 0) $display("FAIL reset_verdict got %0d/%0d/%0d exp 0/0/0", reason, exit_code, cycle_count); else passes++;
        rst = 0;
        @(negedge clk);
        checks++; if (core_rst_n !== 1'b0) $display("FAIL idle_core_rst_n got %b exp 0", core_rst_n); else passes++;
        go_run(lows);
        checks++; if (lows !== 2) $display("FAIL reset_len got %0d exp 2", lows); else passes++;
        checks++; if (running !== 1'b1 || cycle_count !== 1) $display("FAIL first_run got %b/%0d exp 1/1", running, cycle_count); else passes++;
    endtask

    task automatic test_pass;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (cycle_count !== k) $display("FAIL run_count got %0d exp %0d", cycle_count, k); else passes++;
            cyc(32'h100 + 4 * k, 0, 0, 0);
        end
        q.push_back('{3'd1, 1'b1, 32'd0, 32'd5});
        cyc(32'h114, 1, 32'hFC, 32'd1);
        e = q.pop_front();
        checks++; if (done !== 1'b1 || core_rst_n !== 1'b0 || running !== 1'b0) $display("FAIL pass_done got %b%b%b exp 100", done, core_rst_n, running); else passes++;
        checks++; if (reason !== e.reason || pass !== e.pass) $display("FAIL pass_verdict got %0d/%b exp %0d/%b", reason, pass, e.reason, e.pass); else passes++;
        checks++; if (exit_code !== e.exit_code || cycle_count !== e.cnt) $display("FAIL pass_code got %0d/%0d exp %0d/%0d", exit_code, cycle_count, e.exit_code, e.cnt); else passes++;
        cyc(32'h118, 1, 32'hFC, 32'd9);
        checks++; if (reason !== 3'd1 || cycle_count !== 5 || done !== 1'b1) $display("FAIL done_frozen got %0d/%0d/%b exp 1/5/1", reason, cycle_count, done); else passes++;
    endtask

    task automatic test_restart_fail;
        int lows;
        cyc(0, 0, 0, 0);
        start = 1;
        @(negedge clk);
        start = 0;
        checks++; if (done !== 1'b0 || reason !== 3'd0 || pass !== 1'b0 || cycle_count !== 0) $display("FAIL restart_clear got %b/%0d/%b/%0d exp 0/0/0/0", done, reason, pass, cycle_count); else passes++;
        for (int i = 0; i < 10 && core_rst_n !== 1'b1; i++) @(negedge clk);
        cyc(32'h200, 0, 0, 0);
        cyc(32'h204, 0, 0, 0);
        q.push_back('{3'd2, 1'b0, 32'd3, 32'd3});
        cyc(32'h208, 1, 32'hFC, 32'h7);
        e = q.pop_front();
        checks++; if (done !== 1'b1 || reason !== e.reason || pass !== e.pass) $display("FAIL fail_verdict got %b/%0d/%b exp 1/%0d/%b", done, reason, pass, e.reason, e.pass); else passes++;
        checks++; if (exit_code !== e.exit_code || cycle_count !== e.cnt) $display("FAIL fail_code got %0d/%0d exp %0d/%0d", exit_code, cycle_count, e.exit_code, e.cnt); else passes++;
        go_run(lows);
        cyc(32'h300, 0, 32'hFC, 0);
        q.push_back('{3'd2, 1'b0, 32'h7FFF_FFFF, 32'd2});
        cyc(32'h304, 1, 32'hFC, 32'hFFFF_FFFF);
        e = q.pop_front();
        checks++; if (reason !== e.reason || exit_code !== e.exit_code || cycle_count !== e.cnt) $display("FAIL fail_max got %0d/%h/%0d exp %0d/%h/%0d", reason, exit_code, cycle_count, e.reason, e.exit_code, e.cnt); else passes++;
    endtask

    task automatic test_stall;
        logic [31:0] pat_a[8] = '{32'h10, 32'h14, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40};
        logic [31:0] pat_b[10] = '{32'h40, 32'h40, 32'h40, 32'h44, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40};
        int lows, k;
        go_run(lows);
        q.push_back('{3'd4, 1'b0, 32'd0, 32'd6});
        k = 0;
        while (k < 8 && done !== 1'b1) begin
            cyc(pat_a[k], 0, 0, 0);
            k++;
        end
        e = q.pop_front();
        checks++; if (done !== 1'b1 || reason !== e.reason || cycle_count !== e.cnt) $display("FAIL stall_a got %b/%0d/%0d exp 1/%0d/%0d", done, reason, cycle_count, e.reason, e.cnt); else passes++;
        go_run(lows);
        q.push_back('{3'd4, 1'b0, 32'd0, 32'd8});
        k = 0;
        while (k < 10 && done !== 1'b1) begin
            cyc(pat_b[k], 0, 0, 0);
            k++;
        end
        e = q.pop_front();
        checks++; if (done !== 1'b1 || reason !== e.reason || pass !== e.pass || cycle_count !== e.cnt) $display("FAIL stall_toggle got %b/%0d/%b/%0d exp 1/%0d/%b/%0d", done, reason, pass, cycle_count, e.reason, e.pass, e.cnt); else passes++;
    endtask

    task automatic test_timeout;
        int lows, k;
        go_run(lows);
        q.push_back('{3'd3, 1'b0, 32'd0, 32'd20});
        k = 0;
        while (k < 40 && done !== 1'b1) begin
            cyc(32'h1000 + 4 * k, 0, 0, 0);
            k++;
        end
        e = q.pop_front();
        checks++; if (done !== 1'b1 || reason !== e.reason || pass !== e.pass || cycle_count !== e.cnt) $display("FAIL timeout got %b/%0d/%b/%0d exp 1/%0d/%b/%0d", done, reason, pass, cycle_count, e.reason, e.pass, e.cnt); else passes++;
    endtask

    task automatic test_priority;
        int lows;
        go_run(lows);
        for (int k = 1; k < 20; k++) cyc(32'h2000 + 4 * k, 0, 0, 0);
        q.push_back('{3'd1, 1'b1, 32'd0, 32'd20});
        cyc(32'h3000, 1, 32'hFC, 32'd1);
        e = q.pop_front();
        checks++; if (done !== 1'b1 || reason !== e.reason || pass !== e.pass || cycle_count !== e.cnt) $display("FAIL prio_tohost got %b/%0d/%b/%0d exp 1/%0d/%b/%0d", done, reason, pass, cycle_count, e.reason, e.pass, e.cnt); else passes++;
        go_run(lows);
        for (int k = 1; k <= 16; k++) cyc(32'h2000 + 4 * k, 0, 0, 0);
        q.push_back('{3'd4, 1'b0, 32'd0, 32'd20});
        for (int k = 17; k <= 20 && done !== 1'b1; k++) cyc(32'h5000, 0, 0, 0);
        e = q.pop_front();
        checks++; if (done !== 1'b1 || reason !== e.reason || cycle_count !== e.cnt) $display("FAIL prio_stall got %b/%0d/%0d exp 1/%0d/%0d", done, reason, cycle_count, e.reason, e.cnt); else passes++;
    endtask

    task automatic test_async_reset;
        int lows;
        go_run(lows);
        for (int k = 1; k <= 3; k++) cyc(32'h4000 + 4 * k, 0, 0, 0);
        checks++; if (running !== 1'b1 || cycle_count !== 4) $display("FAIL pre_rst got %b/%0d exp 1/4", running, cycle_count); else passes++;
        #2 rst = 1;
        #1;
        checks++; if (core_rst_n !== 1'b0 || running !== 1'b0 || cycle_count !== 0 || done !== 1'b0) $display("FAIL async_rst got %b/%b/%0d/%b exp 0/0/0/0", core_rst_n, running, cycle_count, done); else passes++;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++; if (core_rst_n !== 1'b0 || running !== 1'b0) $display("FAIL post_rst_idle got %b/%b exp 0/0", core_rst_n, running); else passes++;
    endtask

    initial begin
        rst = 1;
        start = 0;
        pc = 0;
        mem_we = 0;
        mem_addr = 0;
        mem_wdata = 0;
        repeat (2) @(negedge clk);
        test_reset;
        test_pass;
        test_restart_fail;
        test_stall;
        test_timeout;
        test_priority;
        test_async_reset;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
